// File: rtl/woz_sd_arbiter.sv
// Round-robin owner of the shared SD block channel for several track-buffer loaders.
// Each requester's LBA is offset into its own window; ack/strobes go only to the owner.
module woz_sd_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int LBA_WINDOW_SHIFT = 16,
    parameter int ACK_TIMEOUT      = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [32*NUM_REQ-1:0] req_lba,
    input  logic [NUM_REQ-1:0]   req_rd,
    input  logic [NUM_REQ-1:0]   req_wr,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   req_buff_wr,
    input  logic [8*NUM_REQ-1:0] req_buff_din,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic [8:0]           sd_buff_addr,
    input  logic                 sd_buff_wr,
    output logic [7:0]           sd_buff_din,
    output logic                 grant_valid,
    output logic [1:0]           grant_idx,
    output logic                 timeout_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DRAIN} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic            old_ack;
    logic [3:0]      rd4, wr4, pend4;
    logic [31:0]     lba_a [4];
    logic [7:0]      din_a [4];
    logic [2:0]      cand;
    logic [1:0]      pick;
    logic            found;
    logic            do_grant, do_clear, do_drop, to_pulse, cnt_inc;
    logic            unused_addr;

    assign unused_addr = ^sd_buff_addr;

    // Pad per-requester buses to four slots so a 2-bit index always fits.
    assign rd4   = 4'(req_rd);
    assign wr4   = 4'(req_wr);
    assign pend4 = rd4 | wr4;

    for (genvar i = 0; i < 4; i++) begin : g_pad
        if (i < NUM_REQ) begin : g_on
            assign lba_a[i] = req_lba[32*i +: 32];
            assign din_a[i] = req_buff_din[8*i +: 8];
        end else begin : g_off
            assign lba_a[i] = '0;
            assign din_a[i] = '0;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_route
        assign req_ack[i]     = sd_ack & grant_valid & (grant_idx == 2'(i));
        assign req_buff_wr[i] = sd_buff_wr & req_ack[i];
    end

    assign sd_buff_din = grant_valid ? din_a[grant_idx] : 8'h00;

    always_comb begin
        pick  = grant_idx;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, grant_idx} + 3'(k);
            if (cand >= 3'(NUM_REQ))
                cand = cand - 3'(NUM_REQ);
            if (!found && pend4[cand[1:0]]) begin
                found = 1'b1;
                pick  = cand[1:0];
            end
        end
    end

    always_comb begin
        state_n  = state;
        do_grant = 1'b0;
        do_clear = 1'b0;
        do_drop  = 1'b0;
        to_pulse = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!sd_ack && found) begin
                    do_grant = 1'b1;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    do_clear = 1'b1;
                    state_n  = XFER;
                end else if (cnt == CW'(ACK_TIMEOUT)) begin
                    do_clear = 1'b1;
                    do_drop  = 1'b1;
                    to_pulse = 1'b1;
                    state_n  = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            XFER: begin
                if (old_ack && !sd_ack) begin
                    do_drop = 1'b1;
                    state_n = DRAIN;
                end
            end
            DRAIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            sd_lba      <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= 2'(NUM_REQ - 1);
            timeout_err <= 1'b0;
            cnt         <= '0;
            old_ack     <= 1'b0;
        end else begin
            old_ack     <= sd_ack;
            timeout_err <= to_pulse;
            if (cnt_inc)
                cnt <= cnt + 1'b1;
            if (do_grant) begin
                grant_idx   <= pick;
                grant_valid <= 1'b1;
                sd_lba      <= lba_a[pick] + (32'(pick) << LBA_WINDOW_SHIFT);
                sd_rd       <= rd4[pick];
                sd_wr       <= !rd4[pick] && wr4[pick];
                cnt         <= '0;
            end
            if (do_clear) begin
                sd_rd <= 1'b0;
                sd_wr <= 1'b0;
            end
            if (do_drop)
                grant_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_woz_sd_arbiter.sv
// Bench for woz_sd_arbiter: directed scenarios plus randomized transfers
// checked against a round-robin reference model.
module tb_woz_sd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] req_lba;
    logic [1:0]  req_rd, req_wr;
    logic [1:0]  req_ack, req_buff_wr;
    logic [15:0] req_buff_din;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    woz_sd_arbiter #(
        .NUM_REQ(2), .LBA_WINDOW_SHIFT(16), .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .req_lba(req_lba), .req_rd(req_rd), .req_wr(req_wr),
        .req_ack(req_ack), .req_buff_wr(req_buff_wr),
        .req_buff_din(req_buff_din),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .grant_valid(grant_valid), .grant_idx(grant_idx),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_rd = '0;
        req_wr = '0;
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        sd_buff_addr = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_req(input int limit, output bit ok, output int n);
        ok = 0;
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (sd_rd || sd_wr) begin
                ok = 1;
                n = i;
                break;
            end
        end
    endtask

    // Host side of one block: ack high for len cycles, strobes in between.
    task automatic host_block(input int g, input int len, input logic [7:0] exp_din,
                              output int ack_bad, output int leak, output int nstr,
                              output int op_bad, output int din_bad);
        ack_bad = 0; leak = 0; nstr = 0; op_bad = 0; din_bad = 0;
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            sd_ack = 1'b1;
            sd_buff_wr = (c >= 1 && c <= len - 2);
            sd_buff_addr = 9'(c);
            @(negedge clk);
            if (!req_ack[g]) ack_bad++;
            if (req_ack[1-g] || req_buff_wr[1-g]) leak++;
            if (req_buff_wr[g]) nstr++;
            if (c >= 1 && (sd_rd || sd_wr)) op_bad++;
            if (sd_buff_din !== exp_din) din_bad++;
        end
        @(posedge clk);
        #1;
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({sd_rd, sd_wr, sd_lba, grant_valid, grant_idx, timeout_err} !== {2'b00, 32'h0, 1'b0, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL reset: got rd=%b wr=%b lba=%h gv=%b gi=%0d to=%b",
                     sd_rd, sd_wr, sd_lba, grant_valid, grant_idx, timeout_err);
        end
    endtask

    task automatic test_single_read();
        bit ok; int n, ab, lk, ns, ob, db;
        do_reset();
        req_lba = {32'h0000_0020, 32'h1234_5678};
        req_buff_din = 16'h5A00;
        req_rd = 2'b10;
        wait_req(10, ok, n);
        checks++;
        if (!ok || n != 2) begin
            errors++;
            $display("FAIL single_latency: got ok=%b n=%0d want n=2", ok, n);
        end
        checks++;
        if (sd_lba !== 32'h0001_0020 || grant_idx !== 2'd1 || sd_rd !== 1'b1 || sd_wr !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: lba=%h gi=%0d rd=%b wr=%b want 00010020 1 1 0",
                     sd_lba, grant_idx, sd_rd, sd_wr);
        end
        host_block(1, 514, 8'h5A, ab, lk, ns, ob, db);
        req_rd = 2'b00;
        checks++;
        if (ab != 0 || lk != 0 || ob != 0) begin
            errors++;
            $display("FAIL single_xfer: ack_bad=%0d leak=%0d rd_after_ack=%0d want 0", ab, lk, ob);
        end
        checks++;
        if (ns != 512) begin
            errors++;
            $display("FAIL single_strobes: got %0d want 512", ns);
        end
        tick(); tick(); tick();
        checks++;
        if (grant_valid !== 1'b0 || sd_rd !== 1'b0) begin
            errors++;
            $display("FAIL single_release: gv=%b rd=%b want 0 0", grant_valid, sd_rd);
        end
    endtask

    task automatic test_contention();
        bit ok; int n, ab, lk, ns, ob, db;
        int exp_g;
        do_reset();
        req_lba = {32'h0000_0100, 32'h0000_0200};
        req_buff_din = 16'h2211;
        req_rd = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g = k % 2;
            wait_req(10, ok, n);
            checks++;
            if (!ok || grant_idx !== 2'(exp_g) || (k > 0 && n != 3)) begin
                errors++;
                $display("FAIL contention_%0d: ok=%b gi=%0d gap=%0d want gi=%0d gap=3",
                         k, ok, grant_idx, n, exp_g);
            end
            host_block(exp_g, 6, exp_g ? 8'h22 : 8'h11, ab, lk, ns, ob, db);
            checks++;
            if (ab != 0 || lk != 0 || ob != 0 || db != 0 || ns != 4) begin
                errors++;
                $display("FAIL contention_xfer_%0d: ab=%0d lk=%0d ob=%0d db=%0d ns=%0d",
                         k, ab, lk, ob, db, ns);
            end
            req_rd[exp_g] = 1'b0;
            tick();
            req_rd[exp_g] = 1'b1;
        end
        req_rd = 2'b00;
    endtask

    task automatic test_write();
        bit ok; int n, ab, lk, ns, ob, db;
        do_reset();
        req_lba = {32'h0000_0007, 32'h0000_0042};
        req_buff_din = 16'h3CA5;
        req_wr = 2'b01;
        wait_req(10, ok, n);
        checks++;
        if (!ok || sd_wr !== 1'b1 || sd_rd !== 1'b0 || grant_idx !== 2'd0 || sd_lba !== 32'h42) begin
            errors++;
            $display("FAIL write_grant: ok=%b wr=%b rd=%b gi=%0d lba=%h", ok, sd_wr, sd_rd, grant_idx, sd_lba);
        end
        host_block(0, 10, 8'hA5, ab, lk, ns, ob, db);
        req_wr = 2'b00;
        checks++;
        if (db != 0 || ab != 0 || lk != 0 || ob != 0) begin
            errors++;
            $display("FAIL write_xfer: din_bad=%0d ab=%0d lk=%0d ob=%0d want 0", db, ab, lk, ob);
        end
    endtask

    task automatic test_timeout();
        bit ok; int n, hit, ab, lk, ns, ob, db;
        do_reset();
        req_lba = '0;
        req_rd = 2'b01;
        wait_req(10, ok, n);
        req_rd[1] = 1'b1;
        hit = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                hit = i;
                break;
            end
        end
        checks++;
        if (hit != 17 || sd_rd !== 1'b0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout: at=%0d rd=%b gv=%b want 17 0 0", hit, sd_rd, grant_valid);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got %b want 0", timeout_err);
        end
        wait_req(10, ok, n);
        checks++;
        if (!ok || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL timeout_next: ok=%b gi=%0d want 1", ok, grant_idx);
        end
        host_block(1, 4, 8'h00, ab, lk, ns, ob, db);
        req_rd[1] = 1'b0;
        wait_req(10, ok, n);
        checks++;
        if (!ok || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL timeout_retry: ok=%b gi=%0d want 0", ok, grant_idx);
        end
    endtask

    task automatic test_reset_mid_xfer();
        bit ok; int n, bad, ab, lk, ns, ob, db;
        do_reset();
        req_lba = {32'h0, 32'h0000_0055};
        req_rd = 2'b01;
        wait_req(10, ok, n);
        @(posedge clk);
        #1;
        sd_ack = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({sd_rd, sd_wr, sd_lba, grant_valid, grant_idx, timeout_err, req_ack} !== {2'b00, 32'h0, 1'b0, 2'd1, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid: rd=%b wr=%b lba=%h gv=%b gi=%0d ack=%b",
                     sd_rd, sd_wr, sd_lba, grant_valid, grant_idx, req_ack);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sd_rd || grant_valid) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_stale_ack: grants during stale ack=%0d want 0", bad);
        end
        @(posedge clk);
        #1;
        sd_ack = 1'b0;
        wait_req(10, ok, n);
        checks++;
        if (!ok || n != 2 || grant_idx !== 2'd0 || sd_lba !== 32'h55) begin
            errors++;
            $display("FAIL reset_regrant: ok=%b n=%0d gi=%0d lba=%h want n=2 gi=0 lba=55",
                     ok, n, grant_idx, sd_lba);
        end
        host_block(0, 4, 8'h00, ab, lk, ns, ob, db);
        req_rd = 2'b00;
    endtask

    task automatic test_rd_wr_together();
        bit ok; int n, ab, lk, ns, ob, db;
        do_reset();
        req_lba = {32'h0, 32'h0000_0009};
        req_rd = 2'b01;
        req_wr = 2'b01;
        wait_req(10, ok, n);
        checks++;
        if (!ok || sd_rd !== 1'b1 || sd_wr !== 1'b0 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL rdwr_first: ok=%b rd=%b wr=%b gi=%0d want rd", ok, sd_rd, sd_wr, grant_idx);
        end
        host_block(0, 4, 8'h00, ab, lk, ns, ob, db);
        req_rd = 2'b00;
        wait_req(10, ok, n);
        checks++;
        if (!ok || sd_wr !== 1'b1 || sd_rd !== 1'b0 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL rdwr_second: ok=%b rd=%b wr=%b gi=%0d want wr", ok, sd_rd, sd_wr, grant_idx);
        end
        host_block(0, 4, 8'h00, ab, lk, ns, ob, db);
        req_wr = 2'b00;
    endtask

    task automatic test_random();
        bit ok; int n, ab, lk, ns, ob, db;
        bit prd[2], pwr[2];
        logic [31:0] mlba[2];
        logic [15:0] dn;
        logic [31:0] exp_lba;
        int last, g;
        bit exp_rd;
        do_reset();
        prd = '{0, 0};
        pwr = '{0, 0};
        mlba = '{32'h0, 32'h0};
        last = 1;
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!prd[i] && !pwr[i] && $urandom_range(0, 1) == 1) begin
                    prd[i] = 1'($urandom_range(0, 1));
                    pwr[i] = !prd[i] || ($urandom_range(0, 1) == 1);
                    mlba[i] = $urandom;
                end
            end
            if (!prd[0] && !pwr[0] && !prd[1] && !pwr[1]) begin
                g = $urandom_range(0, 1);
                prd[g] = 1'b1;
                mlba[g] = $urandom;
            end
            dn = 16'($urandom);
            req_buff_din = dn;
            for (int i = 0; i < 2; i++) begin
                req_rd[i] = prd[i];
                req_wr[i] = pwr[i];
                req_lba[32*i +: 32] = mlba[i];
            end
            g = (prd[(last+1)%2] || pwr[(last+1)%2]) ? (last + 1) % 2 : last;
            exp_rd = prd[g];
            exp_lba = mlba[g] + (32'(g) << 16);
            wait_req(20, ok, n);
            checks++;
            if (!ok || grant_idx !== 2'(g) || sd_lba !== exp_lba || sd_rd !== exp_rd || sd_wr !== !exp_rd) begin
                errors++;
                $display("FAIL rand_grant_%0d: gi=%0d lba=%h rd=%b wr=%b want gi=%0d lba=%h rd=%b",
                         t, grant_idx, sd_lba, sd_rd, sd_wr, g, exp_lba, exp_rd);
            end
            mlba[g] = $urandom;
            req_lba[32*g +: 32] = mlba[g];
            host_block(g, $urandom_range(3, 8), dn[8*g +: 8], ab, lk, ns, ob, db);
            checks++;
            if (ab != 0 || lk != 0 || ob != 0 || db != 0 || sd_lba !== exp_lba) begin
                errors++;
                $display("FAIL rand_xfer_%0d: ab=%0d lk=%0d ob=%0d db=%0d lba=%h want lba=%h",
                         t, ab, lk, ob, db, sd_lba, exp_lba);
            end
            if (exp_rd)
                prd[g] = 1'b0;
            else
                pwr[g] = 1'b0;
            req_rd[g] = prd[g];
            req_wr[g] = pwr[g];
            last = g;
        end
        req_rd = 2'b00;
        req_wr = 2'b00;
    endtask

    initial begin
        reset = 1'b1;
        req_lba = '0;
        req_rd = '0;
        req_wr = '0;
        req_buff_din = '0;
        sd_ack = 1'b0;
        sd_buff_addr = '0;
        sd_buff_wr = 1'b0;
        #1;
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_timeout();
        test_reset_mid_xfer();
        test_rd_wr_together();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
